// File: rtl/dr_bus_ctrl.sv
// -----------------------------------------------------------------------------
// dr_bus_ctrl
//   Arbitrates two requesters (A, B) for a shared data register (DR) and its
//   bus. A granted requester either loads DR from the bus or drives DR onto
//   the high half, low half or both halves for DRIVE_CYC cycles.
//
// Handshake: a requester raises REQ_x with a valid OP_x and holds REQ_x until
//   it sees ACK_x. OP_x is captured once, in the cycle the request is accepted,
//   and is ignored afterwards. ACK_x is a single-cycle completion pulse. If
//   REQ_x is dropped early the operation still completes and ACK_x still
//   pulses. A REQ_x still high after ACK_x counts as a new request.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   REQ_A/OP_A        requester A request and opcode
//   REQ_B/OP_B        requester B request and opcode
//                     (00 load, 01 drive high, 10 drive low, 11 drive both)
//   DR_LOAD           DR load strobe
//   DR_BUS_H/DR_BUS_L DR bus-half drive enables
//   GNT_A/GNT_B       requester owns DR and bus
//   ACK_A/ACK_B       operation-complete pulse
//   BUSY              controller not idle
//   dbg_state         current FSM state encoding (IDLE=0 .. DONE=4)
//
// All outputs come straight from flops: the next output values are decoded
// from the next-state signals and registered alongside the state.
// -----------------------------------------------------------------------------
module dr_bus_ctrl #(
   parameter int DRIVE_CYC = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ_A,
   input  logic [1:0] OP_A,
   input  logic       REQ_B,
   input  logic [1:0] OP_B,
   output logic       DR_LOAD,
   output logic       DR_BUS_H,
   output logic       DR_BUS_L,
   output logic       GNT_A,
   output logic       GNT_B,
   output logic       ACK_A,
   output logic       ACK_B,
   output logic       BUSY,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      LOAD  = 3'd2,
      DRIVE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(DRIVE_CYC - 1);

   state_t     state, state_n;
   logic       owner, owner_n;     // 0 = A, 1 = B
   logic [1:0] op_q, op_n;
   logic [3:0] cnt, cnt_n;
   logic       prio_b, prio_n;     // 1 = B wins the next tie

   logic       pick_b;
   logic       owns;
   logic       dr_load_n, bus_h_n, bus_l_n;
   logic       gnt_a_n, gnt_b_n, ack_a_n, ack_b_n, busy_n;

   // Next-state logic
   always_comb begin
      state_n = state;
      owner_n = owner;
      op_n    = op_q;
      cnt_n   = cnt;
      prio_n  = prio_b;
      // A lone request wins; a tie goes to whoever prio_b favours.
      pick_b  = (REQ_A && REQ_B) ? prio_b : REQ_B;

      unique case (state)
         IDLE: begin
            if (REQ_A || REQ_B) begin
               state_n = GRANT;
               owner_n = pick_b;
               op_n    = pick_b ? OP_B : OP_A;
            end
         end
         GRANT: begin
            if (op_q == 2'b00) begin
               state_n = LOAD;
            end else begin
               state_n = DRIVE;
               cnt_n   = CNT_INIT;
            end
         end
         LOAD: begin
            state_n = DONE;
            prio_n  = ~owner;   // the requester just served loses the next tie
         end
         DRIVE: begin
            if (cnt == 4'd0) begin
               state_n = DONE;
               prio_n  = ~owner;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Next output values, decoded from the next state so that the
   // registered outputs line up with the registered state.
   always_comb begin
      owns      = (state_n == GRANT) || (state_n == LOAD) || (state_n == DRIVE);
      gnt_a_n   = owns && !owner_n;
      gnt_b_n   = owns &&  owner_n;
      dr_load_n = (state_n == LOAD);
      bus_h_n   = (state_n == DRIVE) && op_n[0];
      bus_l_n   = (state_n == DRIVE) && op_n[1];
      ack_a_n   = (state_n == DONE) && !owner_n;
      ack_b_n   = (state_n == DONE) &&  owner_n;
      busy_n    = (state_n != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         owner    <= 1'b0;
         op_q     <= 2'b00;
         cnt      <= 4'd0;
         prio_b   <= 1'b0;
         GNT_A    <= 1'b0;
         GNT_B    <= 1'b0;
         DR_LOAD  <= 1'b0;
         DR_BUS_H <= 1'b0;
         DR_BUS_L <= 1'b0;
         ACK_A    <= 1'b0;
         ACK_B    <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state    <= state_n;
         owner    <= owner_n;
         op_q     <= op_n;
         cnt      <= cnt_n;
         prio_b   <= prio_n;
         GNT_A    <= gnt_a_n;
         GNT_B    <= gnt_b_n;
         DR_LOAD  <= dr_load_n;
         DR_BUS_H <= bus_h_n;
         DR_BUS_L <= bus_l_n;
         ACK_A    <= ack_a_n;
         ACK_B    <= ack_b_n;
         BUSY     <= busy_n;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_dr_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dr_bus_ctrl
//   Directed bench for dr_bus_ctrl. Main instance uses DRIVE_CYC=2; two extra
//   instances (DRIVE_CYC=1 and 15) share the inputs for the drive-length test.
//   Output vector layout used in the expected tables:
//     [7] GNT_A [6] GNT_B [5] DR_LOAD [4] DR_BUS_H [3] DR_BUS_L
//     [2] ACK_A [1] ACK_B [0] BUSY
//   Each table entry is the value observed 1 ns after successive rising edges,
//   the first entry following the edge that samples the request.
// -----------------------------------------------------------------------------
module tb_dr_bus_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       REQ_A, REQ_B;
   logic [1:0] OP_A, OP_B;

   logic       DR_LOAD, DR_BUS_H, DR_BUS_L, GNT_A, GNT_B, ACK_A, ACK_B, BUSY;
   logic [2:0] dbg_state;

   logic       d1_load, d1_h, d1_l, d1_ga, d1_gb, d1_aa, d1_ab, d1_busy;
   logic [2:0] d1_state;
   logic       d15_load, d15_h, d15_l, d15_ga, d15_gb, d15_aa, d15_ab, d15_busy;
   logic [2:0] d15_state;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   dr_bus_ctrl #(.DRIVE_CYC(2)) dut (
      .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .OP_A(OP_A), .REQ_B(REQ_B), .OP_B(OP_B),
      .DR_LOAD(DR_LOAD), .DR_BUS_H(DR_BUS_H), .DR_BUS_L(DR_BUS_L),
      .GNT_A(GNT_A), .GNT_B(GNT_B), .ACK_A(ACK_A), .ACK_B(ACK_B),
      .BUSY(BUSY), .dbg_state(dbg_state)
   );

   dr_bus_ctrl #(.DRIVE_CYC(1)) dut1 (
      .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .OP_A(OP_A), .REQ_B(REQ_B), .OP_B(OP_B),
      .DR_LOAD(d1_load), .DR_BUS_H(d1_h), .DR_BUS_L(d1_l),
      .GNT_A(d1_ga), .GNT_B(d1_gb), .ACK_A(d1_aa), .ACK_B(d1_ab),
      .BUSY(d1_busy), .dbg_state(d1_state)
   );

   dr_bus_ctrl #(.DRIVE_CYC(15)) dut15 (
      .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .OP_A(OP_A), .REQ_B(REQ_B), .OP_B(OP_B),
      .DR_LOAD(d15_load), .DR_BUS_H(d15_h), .DR_BUS_L(d15_l),
      .GNT_A(d15_ga), .GNT_B(d15_gb), .ACK_A(d15_aa), .ACK_B(d15_ab),
      .BUSY(d15_busy), .dbg_state(d15_state)
   );

   function automatic logic [7:0] outs();
     return {GNT_A, GNT_B, DR_LOAD, DR_BUS_H, DR_BUS_L, ACK_A, ACK_B, BUSY};
   endfunction

   task automatic tick();
     @(posedge CLK);
     #1;
   endtask

   task automatic do_reset();
     RST = 1'b1;
     REQ_A = 1'b0; REQ_B = 1'b0; OP_A = 2'b00; OP_B = 2'b00;
     tick();
     tick();
     RST = 1'b0;
   endtask

   task automatic test_reset();
     do_reset();
     checks++;
     if (outs() !== 8'h00) begin
       errors++;
       $display("FAIL reset_outs got %b exp %b", outs(), 8'h00);
     end
     checks++;
     if (dbg_state !== 3'd0) begin
       errors++;
       $display("FAIL reset_state got %0d exp 0", dbg_state);
     end
   endtask

   task automatic test_load_a();
     logic [7:0] exp [4] = '{8'b1000_0001, 8'b1010_0001, 8'b0000_0101, 8'b0000_0000};
     REQ_A = 1'b1; OP_A = 2'b00;
     for (int i = 0; i < 4; i++) begin
       tick();
       checks++;
       if (outs() !== exp[i]) begin
         errors++;
         $display("FAIL load_a[%0d] got %b exp %b", i, outs(), exp[i]);
       end
       if (i == 2) REQ_A = 1'b0;
     end
   endtask

   task automatic test_drive_b();
     logic [7:0] exp [5] = '{8'b0100_0001, 8'b0101_1001, 8'b0101_1001,
                             8'b0000_0011, 8'b0000_0000};
     REQ_B = 1'b1; OP_B = 2'b11;
     for (int i = 0; i < 5; i++) begin
       tick();
       checks++;
       if (outs() !== exp[i]) begin
         errors++;
         $display("FAIL drive_b[%0d] got %b exp %b", i, outs(), exp[i]);
       end
       if (i == 3) REQ_B = 1'b0;
     end
   endtask

   // A and B request together after reset; A keeps requesting after its ACK,
   // so B must still win the second round.
   task automatic test_tie_round_robin();
     logic [7:0] exp [10] = '{8'b1000_0001, 8'b1001_0001, 8'b1001_0001, 8'b0000_0101,
                              8'b0000_0000, 8'b0100_0001, 8'b0100_1001, 8'b0100_1001,
                              8'b0000_0011, 8'b0000_0000};
     do_reset();
     REQ_A = 1'b1; OP_A = 2'b01;
     REQ_B = 1'b1; OP_B = 2'b10;
     for (int i = 0; i < 10; i++) begin
       tick();
       checks++;
       if (outs() !== exp[i] || (GNT_A && GNT_B)) begin
         errors++;
         $display("FAIL tie_rr[%0d] got %b exp %b", i, outs(), exp[i]);
       end
       if (i == 8) begin
         REQ_A = 1'b0;
         REQ_B = 1'b0;
       end
     end
   endtask

   task automatic test_op_change();
     logic [7:0] exp [5] = '{8'b1000_0001, 8'b1001_0001, 8'b1001_0001,
                             8'b0000_0101, 8'b0000_0000};
     REQ_A = 1'b1; OP_A = 2'b01;
     for (int i = 0; i < 5; i++) begin
       tick();
       checks++;
       if (outs() !== exp[i]) begin
         errors++;
         $display("FAIL op_change[%0d] got %b exp %b", i, outs(), exp[i]);
       end
       if (i == 0) OP_A = 2'b10;
       if (i == 3) REQ_A = 1'b0;
     end
   endtask

   task automatic test_req_drop();
     logic [7:0] exp [4] = '{8'b0100_0001, 8'b0110_0001, 8'b0000_0011, 8'b0000_0000};
     REQ_B = 1'b1; OP_B = 2'b00;
     for (int i = 0; i < 4; i++) begin
       tick();
       checks++;
       if (outs() !== exp[i]) begin
         errors++;
         $display("FAIL req_drop[%0d] got %b exp %b", i, outs(), exp[i]);
       end
       if (i == 0) REQ_B = 1'b0;
     end
   endtask

   task automatic test_reset_mid();
     logic [7:0] exp [9] = '{8'b1000_0001, 8'b1001_1001, 8'b1001_1001, 8'b0000_0000,
                             8'b0000_0000, 8'b0100_0001, 8'b0110_0001, 8'b0000_0011,
                             8'b0000_0000};
     REQ_A = 1'b1; OP_A = 2'b11;
     for (int i = 0; i < 9; i++) begin
       tick();
       checks++;
       if (outs() !== exp[i]) begin
         errors++;
         $display("FAIL reset_mid[%0d] got %b exp %b", i, outs(), exp[i]);
       end
       if (i == 2) begin
         RST = 1'b1;
         REQ_A = 1'b0;
       end
       if (i == 3) begin
         RST = 1'b0;
         checks++;
         if (dbg_state !== 3'd0) begin
           errors++;
           $display("FAIL reset_mid_state got %0d exp 0", dbg_state);
         end
       end
       if (i == 4) begin
         REQ_B = 1'b1;
         OP_B = 2'b00;
       end
       if (i == 7) REQ_B = 1'b0;
     end
   endtask

   task automatic test_drive_cyc();
     int  n1 = 0;
     int  n15 = 0;
     bit  ack1 = 1'b0;
     bit  ack15 = 1'b0;
     do_reset();
     REQ_A = 1'b1; OP_A = 2'b11;
     for (int i = 0; i < 24; i++) begin
       tick();
       if (d1_h && d1_l) n1++;
       if (d15_h && d15_l) n15++;
       if (d1_aa) begin
         ack1 = 1'b1;
         REQ_A = 1'b0;
       end
       if (d15_aa) ack15 = 1'b1;
     end
     REQ_A = 1'b0;
     checks++;
     if (n1 !== 1) begin
       errors++;
       $display("FAIL drive_cyc1_len got %0d exp 1", n1);
     end
     checks++;
     if (n15 !== 15) begin
       errors++;
       $display("FAIL drive_cyc15_len got %0d exp 15", n15);
     end
     checks++;
     if (ack1 !== 1'b1 || ack15 !== 1'b1) begin
       errors++;
       $display("FAIL drive_cyc_ack got %b%b exp 11", ack1, ack15);
     end
   endtask

   initial begin
     test_reset();
     test_load_a();
     test_drive_b();
     test_tie_round_robin();
     test_op_change();
     test_req_drop();
     test_reset_mid();
     test_drive_cyc();
     $display("CHECKS %0d ERRORS %0d", checks, errors);
     $finish;
   end

endmodule
